// File: rtl/nbit_serial_reader_if.sv
// rtl/nbit_serial_reader_if.sv - load/shift handshake and serial output bundle for nbit_serial_reader
interface nbit_serial_reader_if #(
  parameter int N = 8
);
  logic         Load;
  logic [N-1:0] D;
  logic         En;
  logic         Rdy;
  logic         Busy;
  logic         Sout;
  logic         SValid;
  logic         Done;

  modport master (
    output Load, D, En,
    input  Rdy, Busy, Sout, SValid, Done
  );

  modport slave (
    input  Load, D, En,
    output Rdy, Busy, Sout, SValid, Done
  );
endinterface

// File: rtl/nbit_serial_reader.sv
// rtl/nbit_serial_reader.sv - parallel-in/serial-out register reader with Done pulse
// Optional even-parity trailer bit enabled by defining NBIT_SERIAL_READER_PARITY_EN.
module nbit_serial_reader #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                 Clk,
  input logic                 R,
  nbit_serial_reader_if.slave bus
);
  localparam int              CW   = $clog2(N + 1);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef NBIT_SERIAL_READER_PARITY_EN
    , PAR = 2'd3
`endif
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  sreg;
  logic [CW-1:0] cnt;
  logic          last_bit;
  logic          head;
`ifdef NBIT_SERIAL_READER_PARITY_EN
  logic          par;
`endif

  assign last_bit = (cnt == LAST);
  // The shift register always presents the next bit at one fixed end.
  assign head     = MSB_FIRST ? sreg[N-1] : sreg[0];

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.Load) state_nxt = SHIFT;
      SHIFT: if (bus.En && last_bit) begin
`ifdef NBIT_SERIAL_READER_PARITY_EN
        state_nxt = PAR;
`else
        state_nxt = DONE;
`endif
      end
`ifdef NBIT_SERIAL_READER_PARITY_EN
      PAR:   if (bus.En) state_nxt = DONE;
`endif
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      sreg <= '0;
      cnt  <= '0;
`ifdef NBIT_SERIAL_READER_PARITY_EN
      par  <= 1'b0;
`endif
    end else if (state == IDLE && bus.Load) begin
      sreg <= bus.D;
      cnt  <= '0;
`ifdef NBIT_SERIAL_READER_PARITY_EN
      par  <= ^bus.D;
`endif
    end else if (state == SHIFT && bus.En) begin
      sreg <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
      cnt  <= cnt + CW'(1);
    end
  end

  always_comb begin
    bus.Rdy    = (state == IDLE);
    bus.Busy   = 1'b0;
    bus.Sout   = 1'b0;
    bus.SValid = 1'b0;
    bus.Done   = 1'b0;
    case (state)
      SHIFT: begin
        bus.Busy   = 1'b1;
        bus.Sout   = head;
        bus.SValid = bus.En;
      end
`ifdef NBIT_SERIAL_READER_PARITY_EN
      PAR: begin
        bus.Busy   = 1'b1;
        bus.Sout   = par;
        bus.SValid = bus.En;
      end
`endif
      DONE:    bus.Done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_nbit_serial_reader.sv
// tb/tb_nbit_serial_reader.sv - directed self-checking bench for nbit_serial_reader
module tb_nbit_serial_reader;
  logic Clk = 1'b0;
  logic R;
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  nbit_serial_reader_if #(.N(8)) b0 ();
  nbit_serial_reader_if #(.N(8)) b1 ();
  nbit_serial_reader_if #(.N(1)) b2 ();

  nbit_serial_reader #(.N(8), .MSB_FIRST(1'b0)) dut0 (.Clk(Clk), .R(R), .bus(b0));
  nbit_serial_reader #(.N(8), .MSB_FIRST(1'b1)) dut1 (.Clk(Clk), .R(R), .bus(b1));
  nbit_serial_reader #(.N(1), .MSB_FIRST(1'b0)) dut2 (.Clk(Clk), .R(R), .bus(b2));

  // {Sout, SValid, Busy, Rdy, Done}
  wire [4:0] o0 = {b0.Sout, b0.SValid, b0.Busy, b0.Rdy, b0.Done};
  wire [4:0] o1 = {b1.Sout, b1.SValid, b1.Busy, b1.Rdy, b1.Done};
  wire [4:0] o2 = {b2.Sout, b2.SValid, b2.Busy, b2.Rdy, b2.Done};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    R = 1'b0;
    #2;
    total++; if (o0 !== 5'b00010) begin bad++; $display("FAIL reset_dut0 got=%b want=%b", o0, 5'b00010); end
    total++; if (o1 !== 5'b00010) begin bad++; $display("FAIL reset_dut1 got=%b want=%b", o1, 5'b00010); end
    total++; if (o2 !== 5'b00010) begin bad++; $display("FAIL reset_dut2 got=%b want=%b", o2, 5'b00010); end
    b0.D = 8'hFF;
    b0.Load = 1'b1;
    tick();
    total++; if (o0 !== 5'b00010) begin bad++; $display("FAIL reset_wins_load got=%b want=%b", o0, 5'b00010); end
    b0.Load = 1'b0;
    R = 1'b1;
    tick();
    total++; if (o0 !== 5'b00010) begin bad++; $display("FAIL reset_release_idle got=%b want=%b", o0, 5'b00010); end
  endtask

  task automatic test_lsb_a5();
    logic [7:0] w;
    logic [4:0] exp;
    w = 8'hA5;
    b0.D = w;
    b0.Load = 1'b1;
    tick();
    b0.Load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {w[i], 4'b1100};
      total++; if (o0 !== exp) begin bad++; $display("FAIL a5_bit%0d got=%b want=%b", i, o0, exp); end
      tick();
    end
`ifdef NBIT_SERIAL_READER_PARITY_EN
    total++; if (o0 !== 5'b01100) begin bad++; $display("FAIL a5_parity got=%b want=%b", o0, 5'b01100); end
    tick();
`endif
    total++; if (o0 !== 5'b00001) begin bad++; $display("FAIL a5_done got=%b want=%b", o0, 5'b00001); end
    tick();
    total++; if (o0 !== 5'b00010) begin bad++; $display("FAIL a5_rdy got=%b want=%b", o0, 5'b00010); end
  endtask

  task automatic test_msb_stall();
    logic [7:0] w;
    logic [4:0] exp;
    int k;
    w = 8'h01;
    k = 0;
    b1.D = w;
    b1.Load = 1'b1;
    tick();
    b1.Load = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      b1.En = (c == 3 || c == 4) ? 1'b0 : 1'b1;
      #1;
      if (b1.En) begin
        exp = {w[7-k], 4'b1100};
        k++;
      end else begin
        exp = {w[7-k], 4'b0100};
      end
      total++; if (o1 !== exp) begin bad++; $display("FAIL msb_cycle%0d got=%b want=%b", c, o1, exp); end
      tick();
    end
    b1.En = 1'b1;
    #1;
`ifdef NBIT_SERIAL_READER_PARITY_EN
    total++; if (o1 !== 5'b11100) begin bad++; $display("FAIL msb_parity got=%b want=%b", o1, 5'b11100); end
    tick();
`endif
    total++; if (o1 !== 5'b00001) begin bad++; $display("FAIL msb_done got=%b want=%b", o1, 5'b00001); end
    tick();
  endtask

  task automatic test_load_during_shift();
    int dones;
    dones = 0;
    b0.D = 8'h00;
    b0.Load = 1'b1;
    tick();
    b0.Load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin
        b0.D = 8'hFF;
        b0.Load = 1'b1;
      end else if (c == 4) begin
        b0.Load = 1'b0;
      end
      #1;
      total++; if (o0[4:3] !== 2'b01) begin bad++; $display("FAIL reload_bit%0d got=%b want=%b", c, o0[4:3], 2'b01); end
      if (b0.Done) dones++;
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      if (b0.Done) dones++;
      tick();
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL reload_done_count got=%0d want=%0d", dones, 1); end
    total++; if (o0 !== 5'b00010) begin bad++; $display("FAIL reload_idle got=%b want=%b", o0, 5'b00010); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] w;
    logic [4:0] exp;
    b0.D = 8'hA5;
    b0.Load = 1'b1;
    tick();
    b0.Load = 1'b0;
    tick();
    tick();
    tick();
    R = 1'b0;
    #1;
    total++; if (o0 !== 5'b00010) begin bad++; $display("FAIL abort_same_cycle got=%b want=%b", o0, 5'b00010); end
    tick();
    R = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (o0 !== 5'b00010) begin bad++; $display("FAIL abort_no_done%0d got=%b want=%b", c, o0, 5'b00010); end
    end
    w = 8'h3C;
    b0.D = w;
    b0.Load = 1'b1;
    tick();
    b0.Load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = {w[i], 4'b1100};
      total++; if (o0 !== exp) begin bad++; $display("FAIL after_abort_bit%0d got=%b want=%b", i, o0, exp); end
      tick();
    end
`ifdef NBIT_SERIAL_READER_PARITY_EN
    total++; if (o0 !== 5'b01100) begin bad++; $display("FAIL after_abort_parity got=%b want=%b", o0, 5'b01100); end
    tick();
`endif
    total++; if (o0 !== 5'b00001) begin bad++; $display("FAIL after_abort_done got=%b want=%b", o0, 5'b00001); end
    tick();
  endtask

  task automatic test_n1();
    b2.D = 1'b1;
    b2.Load = 1'b1;
    tick();
    b2.Load = 1'b0;
    total++; if (o2 !== 5'b11100) begin bad++; $display("FAIL n1_bit got=%b want=%b", o2, 5'b11100); end
    tick();
`ifdef NBIT_SERIAL_READER_PARITY_EN
    total++; if (o2 !== 5'b11100) begin bad++; $display("FAIL n1_parity got=%b want=%b", o2, 5'b11100); end
    tick();
`endif
    total++; if (o2 !== 5'b00001) begin bad++; $display("FAIL n1_done got=%b want=%b", o2, 5'b00001); end
    tick();
    total++; if (o2 !== 5'b00010) begin bad++; $display("FAIL n1_rdy got=%b want=%b", o2, 5'b00010); end
  endtask

  initial begin
    b0.Load = 1'b0; b0.D = '0; b0.En = 1'b1;
    b1.Load = 1'b0; b1.D = '0; b1.En = 1'b1;
    b2.Load = 1'b0; b2.D = '0; b2.En = 1'b1;
    test_reset();
    test_lsb_a5();
    test_msb_stall();
    test_load_during_shift();
    test_reset_abort();
    test_n1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
